// File: rtl/jtbubl_pkg.sv
// Shared definitions for the Bubble Bobble ROM arbiter.
//   arb_state_t : arbiter FSM states
//   SLOT_*      : requester slot identifiers
//   kw_max      : widest of three cache key widths (sizes the latched key)
package jtbubl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] SLOT_GFX  = 2'd0;
  localparam logic [1:0] SLOT_MAIN = 2'd1;
  localparam logic [1:0] SLOT_SND  = 2'd2;

  function automatic int kw_max(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/jtbubl_rom_slot.sv
// One requester slot: single-entry, word-granular read cache.
//   cs, addr            : requester strobe and address
//   fill_we/key/data    : cache write from the arbiter (one-cycle strobe)
//   key                 : word key of the live address
//   data                : cached word (DW=32) or selected byte (DW=8)
//   ok                  : hit, combinational on the live address
//   miss                : cs asserted without a hit; asks the arbiter for a fill
module jtbubl_rom_slot #(
  parameter int AW = 17,
  parameter int DW = 8,
  parameter int KW = 15
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill_we,
  input  logic [KW-1:0] fill_key,
  input  logic [31:0]   fill_data,
  output logic [KW-1:0] key,
  output logic [DW-1:0] data,
  output logic          ok,
  output logic          miss
);

  logic          valid_q;
  logic [KW-1:0] tag_q;
  logic [31:0]   word_q;
  logic          hit;

  generate
    if (DW == 32) begin : g_word
      assign key  = addr;
      assign data = word_q;
    end else begin : g_byte
      // Byte lanes are little-endian within the cached word.
      assign key  = addr[AW-1:2];
      assign data = DW'(word_q >> {addr[1:0], 3'b000});
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else if (fill_we) begin
      valid_q <= 1'b1;
      tag_q   <= fill_key;
      word_q  <= fill_data;
    end
  end

  assign hit  = cs & valid_q & (tag_q == key);
  assign ok   = hit;
  assign miss = cs & ~hit;

endmodule

// File: rtl/jtbubl_rom_arb.sv
// Shares the SDRAM read port among gfx (32-bit), main CPU and sound CPU
// (8-bit) ROM requesters, each fronted by a one-word cache.
//   gfx_* / main_* / snd_* : slot cs/addr in, data/ok out
//   sdram_req/addr/ack     : request channel to the SDRAM controller
//   data_rdy/data_read     : read-return channel
//   fsm_state              : current arbiter state, for observation
// Handshake: sdram_req rises with sdram_addr stable and both are held
// unchanged until the cycle sdram_ack is seen; req drops the cycle after.
// Read data is taken on the single data_rdy pulse after (or with) the ack;
// data_rdy arriving in any other state is ignored.
// Grants are fixed priority gfx > main > snd, evaluated only in IDLE, so a
// transfer in flight is never preempted.
module jtbubl_rom_arb
  import jtbubl_pkg::*;
#(
  parameter int          GFX_AW      = 18,
  parameter int          MAIN_AW     = 17,
  parameter int          SND_AW      = 15,
  parameter logic [21:0] GFX_OFFSET  = 22'h10_0000,
  parameter logic [21:0] MAIN_OFFSET = 22'h00_0000,
  parameter logic [21:0] SND_OFFSET  = 22'h08_0000
) (
  input  logic               rst,
  input  logic               clk,
  input  logic               gfx_cs,
  input  logic [GFX_AW-1:0]  gfx_addr,
  output logic [31:0]        gfx_data,
  output logic               gfx_ok,
  input  logic               main_cs,
  input  logic [MAIN_AW-1:0] main_addr,
  output logic [7:0]         main_data,
  output logic               main_ok,
  input  logic               snd_cs,
  input  logic [SND_AW-1:0]  snd_addr,
  output logic [7:0]         snd_data,
  output logic               snd_ok,
  output logic               sdram_req,
  output logic [21:0]        sdram_addr,
  input  logic               sdram_ack,
  input  logic               data_rdy,
  input  logic [31:0]        data_read,
  output logic [1:0]         fsm_state
);

  localparam int GFX_KW  = GFX_AW;
  localparam int MAIN_KW = MAIN_AW - 2;
  localparam int SND_KW  = SND_AW - 2;
  localparam int KW      = kw_max(GFX_KW, MAIN_KW, SND_KW);

  arb_state_t         state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [KW-1:0]      key_q, key_d;
  logic [21:0]        addr_q, addr_d;
  logic               fill;

  logic [GFX_KW-1:0]  gfx_key;
  logic [MAIN_KW-1:0] main_key;
  logic [SND_KW-1:0]  snd_key;
  logic               gfx_miss, main_miss, snd_miss;

  jtbubl_rom_slot #(.AW(GFX_AW), .DW(32), .KW(GFX_KW)) u_gfx (
    .rst(rst), .clk(clk), .cs(gfx_cs), .addr(gfx_addr),
    .fill_we(fill && slot_q == SLOT_GFX), .fill_key(key_q[GFX_KW-1:0]),
    .fill_data(data_read), .key(gfx_key), .data(gfx_data),
    .ok(gfx_ok), .miss(gfx_miss)
  );

  jtbubl_rom_slot #(.AW(MAIN_AW), .DW(8), .KW(MAIN_KW)) u_main (
    .rst(rst), .clk(clk), .cs(main_cs), .addr(main_addr),
    .fill_we(fill && slot_q == SLOT_MAIN), .fill_key(key_q[MAIN_KW-1:0]),
    .fill_data(data_read), .key(main_key), .data(main_data),
    .ok(main_ok), .miss(main_miss)
  );

  jtbubl_rom_slot #(.AW(SND_AW), .DW(8), .KW(SND_KW)) u_snd (
    .rst(rst), .clk(clk), .cs(snd_cs), .addr(snd_addr),
    .fill_we(fill && slot_q == SLOT_SND), .fill_key(key_q[SND_KW-1:0]),
    .fill_data(data_read), .key(snd_key), .data(snd_data),
    .ok(snd_ok), .miss(snd_miss)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= SLOT_GFX;
      key_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      key_q   <= key_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    key_d   = key_q;
    addr_d  = addr_q;
    fill    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gfx_miss) begin
          slot_d  = SLOT_GFX;
          key_d   = KW'(gfx_key);
          addr_d  = GFX_OFFSET + 22'(gfx_key);
          state_d = WAIT_ACK;
        end else if (main_miss) begin
          slot_d  = SLOT_MAIN;
          key_d   = KW'(main_key);
          addr_d  = MAIN_OFFSET + 22'(main_key);
          state_d = WAIT_ACK;
        end else if (snd_miss) begin
          slot_d  = SLOT_SND;
          key_d   = KW'(snd_key);
          addr_d  = SND_OFFSET + 22'(snd_key);
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          // A controller may return data in the ack cycle itself.
          if (data_rdy) begin
            fill    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (data_rdy) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sdram_req  = (state_q == WAIT_ACK);
  assign sdram_addr = addr_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_jtbubl_rom_arb.sv
module tb_jtbubl_rom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        gfx_cs;
  logic [17:0] gfx_addr;
  logic [31:0] gfx_data;
  logic        gfx_ok;
  logic        main_cs;
  logic [16:0] main_addr;
  logic [7:0]  main_data;
  logic        main_ok;
  logic        snd_cs;
  logic [14:0] snd_addr;
  logic [7:0]  snd_data;
  logic        snd_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cs;
    logic [16:0] addr;
    logic        exp_ok;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[6];

  jtbubl_rom_arb dut (
    .rst(rst), .clk(clk),
    .gfx_cs(gfx_cs), .gfx_addr(gfx_addr), .gfx_data(gfx_data), .gfx_ok(gfx_ok),
    .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
    .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_data(snd_data), .snd_ok(snd_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wait_req(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sdram_req) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_req_seen"}, 32'(got), 32'd1);
  endtask

  // Serves one SDRAM read: checks the address, acks, then returns data
  // either one idle cycle later or in the ack cycle itself.
  task automatic serve(input string name, input logic [21:0] exp_addr,
                       input logic [31:0] d, input bit same);
    wait_req(name);
    check({name, "_addr"}, 32'(sdram_addr), 32'(exp_addr));
    if (same) begin
      sdram_ack = 1'b1;
      data_rdy  = 1'b1;
      data_read = d;
      tick();
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
    end else begin
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      check({name, "_req_drop"}, 32'(sdram_req), 32'd0);
      tick();
      data_rdy  = 1'b1;
      data_read = d;
      tick();
      data_rdy  = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 17'h00004, 1'b1, 8'hDD};
    vecs[1] = '{1'b1, 17'h00005, 1'b1, 8'hCC};
    vecs[2] = '{1'b1, 17'h00006, 1'b1, 8'hBB};
    vecs[3] = '{1'b1, 17'h00007, 1'b1, 8'hAA};
    vecs[4] = '{1'b0, 17'h00007, 1'b0, 8'hAA};
    vecs[5] = '{1'b0, 17'h00004, 1'b0, 8'hDD};

    rst = 1'b1;
    gfx_cs = 1'b0; gfx_addr = '0;
    main_cs = 1'b1; main_addr = 17'h00005;
    snd_cs = 1'b0; snd_addr = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    repeat (3) tick();

    // Reset state
    check("rst_main_ok", 32'(main_ok), 32'd0);
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
    check("rst_main_data", 32'(main_data), 32'd0);
    check("rst_gfx_data", gfx_data, 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    rst = 1'b0;

    // First miss on main
    serve("main_first", 22'h000001, 32'hAABBCCDD, 1'b0);
    check("main_first_ok", 32'(main_ok), 32'd1);
    check("main_first_data", 32'(main_data), 32'hCC);

    // Hits from the cached word: zero latency, no SDRAM traffic
    for (int i = 0; i < 6; i++) begin
      main_cs = vecs[i].cs;
      main_addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_ok", i), 32'(main_ok), 32'(vecs[i].exp_ok));
      check($sformatf("vec%0d_data", i), 32'(main_data), 32'(vecs[i].exp_data));
      tick();
      check($sformatf("vec%0d_noreq", i), 32'(sdram_req), 32'd0);
    end

    // Moving to a new word drops ok immediately and refetches
    main_cs = 1'b1;
    main_addr = 17'h00008;
    #1;
    check("newword_ok_drop", 32'(main_ok), 32'd0);
    serve("main_word2", 22'h000002, 32'h11223344, 1'b0);
    check("main_word2_data", 32'(main_data), 32'h44);
    main_cs = 1'b0;

    // Priority: gfx and snd together, gfx served first
    gfx_cs = 1'b1; gfx_addr = 18'h00010;
    snd_cs = 1'b1; snd_addr = 15'h0000;
    serve("prio_gfx", 22'h100010, 32'hDEADBEEF, 1'b0);
    check("prio_gfx_ok", 32'(gfx_ok), 32'd1);
    check("prio_gfx_data", gfx_data, 32'hDEADBEEF);
    check("prio_snd_wait", 32'(snd_ok), 32'd0);
    check("prio_idle_gap", 32'(fsm_state), 32'd0);
    serve("prio_snd", 22'h080000, 32'h55667788, 1'b0);
    check("prio_snd_ok", 32'(snd_ok), 32'd1);
    check("prio_snd_data", 32'(snd_data), 32'h88);
    gfx_cs = 1'b0; snd_cs = 1'b0;

    // Address change while the fill is in flight
    main_cs = 1'b1; main_addr = 17'h00100;
    wait_req("chg");
    check("chg_addr", 32'(sdram_addr), 32'h40);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    main_addr = 17'h00200;
    tick();
    check("chg_no_new_req", 32'(sdram_req), 32'd0);
    data_rdy = 1'b1; data_read = 32'h01020304;
    tick();
    data_rdy = 1'b0;
    check("chg_stale_ok", 32'(main_ok), 32'd0);
    serve("chg_refetch", 22'h000080, 32'h0A0B0C0D, 1'b0);
    check("chg_refetch_ok", 32'(main_ok), 32'd1);
    check("chg_refetch_data", 32'(main_data), 32'h0D);
    main_cs = 1'b0;

    // Ack and data_rdy coincide, top of sound space
    snd_cs = 1'b1; snd_addr = 15'h7FFF;
    serve("same", 22'h081FFF, 32'hCAFEF00D, 1'b1);
    check("same_state_idle", 32'(fsm_state), 32'd0);
    check("same_ok", 32'(snd_ok), 32'd1);
    check("same_data", 32'(snd_data), 32'hCA);

    // Reset in WAIT_DATA, then a late data_rdy
    main_cs = 1'b1; main_addr = 17'h00200;
    gfx_cs = 1'b1; gfx_addr = 18'h3FFFF;
    wait_req("rstmid");
    check("rstmid_addr", 32'(sdram_addr), 32'h13FFFF);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("rstmid_in_wait_data", 32'(fsm_state), 32'd2);
    gfx_cs = 1'b0; main_cs = 1'b0;
    rst = 1'b1;
    #1;
    check("rstmid_state", 32'(fsm_state), 32'd0);
    check("rstmid_req", 32'(sdram_req), 32'd0);
    check("rstmid_sdram_addr", 32'(sdram_addr), 32'd0);
    check("rstmid_snd_ok", 32'(snd_ok), 32'd0);
    check("rstmid_snd_data", 32'(snd_data), 32'd0);
    tick();
    rst = 1'b0;
    snd_cs = 1'b0;
    data_rdy = 1'b1; data_read = 32'hFFFFFFFF;
    tick();
    data_rdy = 1'b0;
    check("late_rdy_state", 32'(fsm_state), 32'd0);
    gfx_cs = 1'b1; main_cs = 1'b1; main_addr = 17'h00005;
    #1;
    check("late_rdy_gfx_ok", 32'(gfx_ok), 32'd0);
    check("late_rdy_main_ok", 32'(main_ok), 32'd0);
    serve("post_rst", 22'h13FFFF, 32'h12345678, 1'b0);
    check("post_rst_gfx_ok", 32'(gfx_ok), 32'd1);
    serve("post_rst_main", 22'h000001, 32'h00C0FFEE, 1'b0);
    check("post_rst_main_data", 32'(main_data), 32'hFF);
    gfx_cs = 1'b0; main_cs = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtbubl_rom_arb.md
# jtbubl_rom_arb

Arbiter that shares the single SDRAM read port among three ROM requesters: object/tile graphics fetch (32-bit words), main CPU program ROM and sound CPU ROM (8-bit). It sits between the game cores and the SDRAM controller. Each slot has a one-entry, word-granular cache so repeated reads complete without SDRAM traffic. Fixed priority keeps the graphics line fill on time.

## Interface
Parameters:
- GFX_AW, 18, gfx slot address width (32-bit word address)
- MAIN_AW, 17, main slot byte address width
- SND_AW, 15, sound slot byte address width
- GFX_OFFSET, 22'h10_0000, SDRAM word offset of gfx region
- MAIN_OFFSET, 22'h00_0000, SDRAM word offset of main region
- SND_OFFSET, 22'h08_0000, SDRAM word offset of sound region

Ports:
- rst  in  1  asynchronous, active-high reset
- clk  in  1  system clock
- gfx_cs / gfx_addr / gfx_data / gfx_ok  in/in/out/out  1/GFX_AW/32/1  gfx slot
- main_cs / main_addr / main_data / main_ok  in/in/out/out  1/MAIN_AW/8/1  main slot
- snd_cs / snd_addr / snd_data / snd_ok  in/in/out/out  1/SND_AW/8/1  sound slot
- sdram_req  out  1  request, held until acknowledged
- sdram_addr  out  22  SDRAM 32-bit word address
- sdram_ack  in  1  one-cycle pulse: request accepted
- data_rdy  in  1  one-cycle pulse: data_read valid
- data_read  in  32  SDRAM read data

## Operation
- Slot word key: gfx = full addr; main/snd = addr[AW-1:2]. SDRAM address = OFFSET + key (22-bit, wraps mod 2^22).
- Per slot cache: valid bit, key tag, 32-bit data. Hit = cs & valid & tag==current key.
- ok = hit, combinational from registered tag vs live address; drops the cycle addr changes to a new word.
- 8-bit data = cached word byte addr[1:0] (0 → [7:0] … 3 → [31:24]); gfx_data = full word.
- FSM states IDLE, WAIT_ACK, WAIT_DATA.
  - IDLE: among slots with cs & !hit, grant gfx > main > snd; latch slot id and key; sdram_req=1, sdram_addr set; → WAIT_ACK.
  - WAIT_ACK: hold req/addr stable; on sdram_ack drop req → WAIT_DATA.
  - WAIT_DATA: on data_rdy write data_read, latched key, valid=1 into granted slot cache; → IDLE.
- Requester dropping cs or changing addr mid-transfer does not abort; fill completes with the latched key (becomes a miss against the new address, re-requested next IDLE).
- No preemption: higher-priority request waits for current transfer.
- sdram_ack and data_rdy in the same cycle in WAIT_ACK: treat as ack then fill, → IDLE.
- data_rdy outside WAIT_DATA ignored.

## Timing
- Reset: sdram_req=0, sdram_addr=0, FSM IDLE, all valid=0, all ok=0, data outputs 0.
- Hit: ok same cycle as cs/addr valid (0 latency).
- Miss: req asserted cycle after cs; ok asserted cycle after data_rdy (cache write then compare).
- Minimum back-to-back: one IDLE cycle between transfers.
- rst mid-transfer clears everything; a late data_rdy after reset is ignored.

## Structure
- Shared package jtbubl_pkg: FSM state enum, slot id constants (SLOT_GFX=0, SLOT_MAIN=1, SLOT_SND=2).
- Sub-module jtbubl_rom_slot (parameter AW, DW, word-key width): cache regs, hit compare, byte select; instantiated three times. Arbiter FSM in top.

## Test plan
- Reset: during rst all ok=0, sdram_req=0; first main_cs addr 17'h00005 → req with sdram_addr 22'h000001, data_rdy 32'hAABBCCDD → main_ok=1, main_data=8'hCC.
- Cache hit: after above, main_addr 17'h00007 → main_ok same cycle, data 8'hAA, no sdram_req.
- Priority: gfx_cs (addr 0x00010) and snd_cs asserted same cycle → first sdram_addr 22'h100010, snd served only after gfx data_rdy.
- Address change in flight: main_addr 0x100 → 0x200 during WAIT_DATA → main_ok stays 0, second request issued for word 0x80.
- Ack+rdy same cycle: ack and data_rdy coincide → FSM back to IDLE, slot ok next cycle.
- Reset mid WAIT_DATA: assert rst, then spurious data_rdy → no cache valid, ok=0.
